spi_master_px: RTL and testbench

- Parameterised full-duplex SPI master for the memory-mapped I/O space.
- Successor to the fixed 8-bit, mode-0-only, output-only SPI driver.
- Adds configurable frame width, clock divider, chip-select count and bit order; runtime CPOL/CPHA selection per frame; MISO capture; busy/done handshake with the CPU-side register logic.

---
 rtl/spi_master_px.sv | 210 +++++++++++++++++++++
 tb/tb_spi_master_px.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_px.sv
// spi_master_px: parameterised full-duplex SPI master.
//
// Ports:
//   clk, reset_          system clock, synchronous active-low reset
//   start                single-cycle frame request, taken only while idle
//   mode, cs_sel, dc_in  {CPOL,CPHA}, chip-select index, data/command flag
//   din                  transmit word
//   miso                 serial data in
//   busy, done           frame in progress / one-cycle completion pulse
//   dout                 last received word
//   sck, mosi, cs_, dc   serial clock, serial data out, active-low selects,
//                        latched data/command flag (all registered)
//
// state | meaning
// IDLE  | waiting for start, sck parked at latched CPOL
// SETUP | cs_ asserted, one half-period before the first sck edge
// XFER  | 2*DATA_W sck edges, shifting mosi and sampling miso
// HOLD  | one half-period after the last edge, then cs_ releases and done pulses
module spi_master_px #(
  parameter int DATA_W    = 8,
  parameter int FREQDIV   = 25,
  parameter int NUM_CS    = 1,
  parameter bit LSB_FIRST = 1'b0,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              dc_in,
  input  logic [DATA_W-1:0] din,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_,
  output logic              dc
);

  localparam int CNT_W  = $clog2(FREQDIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FREQDIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                busy_d, done_d, sck_d, mosi_d, dc_d;
  logic [DATA_W-1:0]   dout_d;
  logic [NUM_CS-1:0]   cs_d;
  logic                lead_edge, last_edge, half_end;

  // Bit next in line to leave the transmit register.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  // Drop the bit just sent so the following one sits in the output position.
  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // An out-of-range index matches no line, so every select stays high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) r[i] = 1'b0;
    return r;
  endfunction

  // edge_q counts edges already made, so an even count means the next edge
  // moves sck away from CPOL (leading edge).
  assign lead_edge = ~edge_q[0];
  assign last_edge = (edge_q == EDGE_LAST);
  assign half_end  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    busy_d  = busy;
    done_d  = 1'b0;
    dout_d  = dout;
    sck_d   = sck;
    mosi_d  = mosi;
    cs_d    = cs_;
    dc_d    = dc;

    case (state_q)
      IDLE: begin
        sck_d = cpol_q;
        if (start && !busy) begin
          state_d = SETUP;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          cpol_d  = mode[1];
          cpha_d  = mode[0];
          sck_d   = mode[1];
          dc_d    = dc_in;
          busy_d  = 1'b1;
          cs_d    = cs_decode(cs_sel);
          if (mode[0]) begin
            tx_d = din;
          end else begin
            // CPHA=0 needs the first bit valid before the first edge.
            mosi_d = first_bit(din);
            tx_d   = shift_tx(din);
          end
        end
      end

      SETUP: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      XFER: begin
        if (half_end) begin
          cnt_d  = '0;
          sck_d  = ~sck;
          edge_d = edge_q + EDGE_W'(1);
          if (cpha_q ? lead_edge : (!lead_edge && !last_edge)) begin
            mosi_d = first_bit(tx_q);
            tx_d   = shift_tx(tx_q);
          end
          if (cpha_q ? !lead_edge : lead_edge)
            rx_d = shift_rx(rx_q, miso);
          if (last_edge)
            state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = rx_q;
          cs_d    = '1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_     <= '1;
      dc      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      busy    <= busy_d;
      done    <= done_d;
      dout    <= dout_d;
      sck     <= sck_d;
      mosi    <= mosi_d;
      cs_     <= cs_d;
      dc      <= dc_d;
    end
  end

endmodule

// File: tb/tb_spi_master_px.sv
// Scoreboard bench for spi_master_px: one MSB-first and one LSB-first build
// share the request inputs; each has its own miso source and monitor.
module tb_spi_master_px;
  localparam int DW       = 8;
  localparam int FD       = 4;
  localparam int NCS      = 3;
  localparam int CSW      = 2;
  localparam int BUSY_LEN = (2 * DW + 2) * FD;

  typedef struct {
    logic [DW-1:0]  dout;
    logic [DW-1:0]  bits;   // bits[k] = k-th bit expected on mosi
    logic [NCS-1:0] cs;
    logic           dc;
    logic [1:0]     mode;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_ = 1'b0;
  logic                start = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic [CSW-1:0]      cs_sel = '0;
  logic                dc_in = 1'b0;
  logic [DW-1:0]       din = '0;
  logic [1:0]          miso_sel = 2'd0;   // 0 loopback, 1 inverted loopback, 2 tie 0, 3 tie 1
  logic [1:0]          miso, busy, done, sck, mosi, dc;
  logic [1:0][DW-1:0]  dout;
  logic [1:0][NCS-1:0] cs_;

  exp_t sbq [2][$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign miso[g] = (miso_sel == 2'd0) ? mosi[g] :
                     (miso_sel == 2'd1) ? ~mosi[g] : miso_sel[0];

    spi_master_px #(
      .DATA_W(DW), .FREQDIV(FD), .NUM_CS(NCS), .LSB_FIRST(g == 1)
    ) u_dut (
      .clk(clk), .reset_(reset_), .start(start), .mode(mode), .cs_sel(cs_sel),
      .dc_in(dc_in), .din(din), .miso(miso[g]), .busy(busy[g]), .done(done[g]),
      .dout(dout[g]), .sck(sck[g]), .mosi(mosi[g]), .cs_(cs_[g]), .dc(dc[g])
    );

    // Acts as the SPI slave: captures mosi on every sampling edge of sck and
    // checks the frame envelope against the scoreboard.
    initial begin : mon
      int            blen;
      int            nb;
      logic [DW-1:0] cap;
      logic          pb, ps, pd;
      exp_t          e;
      blen = 0; nb = 0; cap = '0; pb = 1'b0; ps = 1'b0; pd = 1'b0;
      e = '{default: '0};
      forever begin
        @(negedge clk);
        if (!reset_) begin
          blen = 0; nb = 0; cap = '0; pb = 1'b0; pd = 1'b0; ps = sck[g];
        end else begin
          if (busy[g]) begin
            if (!pb) begin
              blen = 0; nb = 0; cap = '0;
              if (sbq[g].size() == 0) begin
                checks++; errors++;
                $display("FAIL u%0d unexpected_busy got=busy exp=no frame pending", g);
              end else begin
                e = sbq[g][0];
                chk($sformatf("u%0d cs_in_frame", g), 32'(cs_[g]), 32'(e.cs));
                chk($sformatf("u%0d dc_in_frame", g), 32'(dc[g]), 32'(e.dc));
                chk($sformatf("u%0d sck_setup", g), 32'(sck[g]), 32'(e.mode[1]));
              end
            end else if (sck[g] != ps && sck[g] == ~(e.mode[1] ^ e.mode[0])) begin
              if (nb < DW) cap[nb] = mosi[g];
              nb++;
            end
            blen++;
          end
          if (done[g]) begin
            chk($sformatf("u%0d done_width", g), 32'(pd), 32'd0);
            if (sbq[g].size() == 0) begin
              checks++; errors++;
              $display("FAIL u%0d unexpected_done got=done exp=no frame pending", g);
            end else begin
              e = sbq[g].pop_front();
              chk($sformatf("u%0d dout", g), 32'(dout[g]), 32'(e.dout));
              chk($sformatf("u%0d mosi_bits", g), 32'(cap), 32'(e.bits));
              chk($sformatf("u%0d sample_edges", g), 32'(nb), 32'(DW));
              chk($sformatf("u%0d busy_len", g), 32'(blen), 32'(BUSY_LEN));
              chk($sformatf("u%0d busy_at_done", g), 32'(busy[g]), 32'd0);
              chk($sformatf("u%0d cs_at_done", g), 32'(cs_[g]), 32'((1 << NCS) - 1));
              chk($sformatf("u%0d sck_idle", g), 32'(sck[g]), 32'(e.mode[1]));
              chk($sformatf("u%0d dc_hold", g), 32'(dc[g]), 32'(e.dc));
            end
          end
          pb = busy[g]; ps = sck[g]; pd = done[g];
        end
      end
    end
  end

  // Called at posedge+1 when the DUTs will accept on the next edge.
  task automatic issue(input logic [1:0] m, input logic [CSW-1:0] sel, input logic dci,
                       input logic [DW-1:0] d, input logic [1:0] ms);
    exp_t e;
    mode = m; cs_sel = sel; dc_in = dci; din = d; miso_sel = ms; start = 1'b1;
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < DW; k++) e.bits[k] = (g == 1) ? d[k] : d[DW-1-k];
      case (ms)
        2'd0:    e.dout = d;
        2'd1:    e.dout = ~d;
        2'd2:    e.dout = '0;
        default: e.dout = '1;
      endcase
      e.cs = '1;
      if (int'(sel) < NCS) e.cs[sel] = 1'b0;
      e.dc   = dci;
      e.mode = m;
      sbq[g].push_back(e);
    end
    @(posedge clk); #1;
    start  = 1'b0;
    mode   = 2'($urandom);
    din    = DW'($urandom);
    dc_in  = ~dci;
    cs_sel = CSW'($urandom);
  endtask

  // Returns at posedge+1 in the done cycle.
  task automatic wait_done();
    int n;
    n = 0;
    while (done[0] !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done[0]), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [NCS-1:0] cs_exp;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d rst_busy", g), 32'(busy[g]), 32'd0);
      chk($sformatf("u%0d rst_done", g), 32'(done[g]), 32'd0);
      chk($sformatf("u%0d rst_dout", g), 32'(dout[g]), 32'd0);
      chk($sformatf("u%0d rst_sck", g), 32'(sck[g]), 32'd0);
      chk($sformatf("u%0d rst_mosi", g), 32'(mosi[g]), 32'd0);
      chk($sformatf("u%0d rst_cs", g), 32'(cs_[g]), 32'((1 << NCS) - 1));
      chk($sformatf("u%0d rst_dc", g), 32'(dc[g]), 32'd0);
    end
    reset_ = 1'b1;
    idle(3);

    // Mode 00 loopback, then mode 11 with miso tied high
    issue(2'b00, 2'd0, 1'b1, 8'hA5, 2'd0);
    wait_done();
    idle(4);
    issue(2'b11, 2'd1, 1'b0, 8'h3C, 2'd3);
    wait_done();
    idle(4);

    // A start (with din=0) 20 cycles into a frame must be ignored
    issue(2'b01, 2'd2, 1'b1, 8'h5A, 2'd0);
    idle(19);
    start = 1'b1; din = 8'h00; mode = 2'b10;
    idle(1);
    start = 1'b0;
    wait_done();
    idle(FD * 10);

    // Out-of-range select: no line asserts, frame still completes
    issue(2'b10, 2'd3, 1'b0, 8'hC3, 2'd1);
    wait_done();
    idle(4);

    // Reset 30 cycles into a mode-11 frame aborts it
    issue(2'b11, 2'd0, 1'b1, 8'hFF, 2'd3);
    idle(29);
    reset_ = 1'b0;
    idle(1);
    reset_ = 1'b1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d abort_busy", g), 32'(busy[g]), 32'd0);
      chk($sformatf("u%0d abort_done", g), 32'(done[g]), 32'd0);
      chk($sformatf("u%0d abort_cs", g), 32'(cs_[g]), 32'((1 << NCS) - 1));
      chk($sformatf("u%0d abort_sck", g), 32'(sck[g]), 32'd0);
      chk($sformatf("u%0d abort_mosi", g), 32'(mosi[g]), 32'd0);
      chk($sformatf("u%0d abort_dout", g), 32'(dout[g]), 32'd0);
      chk($sformatf("u%0d abort_dc", g), 32'(dc[g]), 32'd0);
      sbq[g].delete();
    end
    idle(BUSY_LEN + 10);
    for (int g = 0; g < 2; g++)
      chk($sformatf("u%0d post_abort_sck", g), 32'(sck[g]), 32'd0);

    // din=0x01 in mode 01, then a start in the done cycle
    issue(2'b01, 2'd0, 1'b0, 8'h01, 2'd0);
    wait_done();
    for (int g = 0; g < 2; g++)
      chk($sformatf("u%0d b2b_gap_cs", g), 32'(cs_[g]), 32'((1 << NCS) - 1));
    issue(2'b00, 2'd1, 1'b1, 8'h96, 2'd1);
    for (int g = 0; g < 2; g++)
      chk($sformatf("u%0d b2b_cs_low", g), 32'(cs_[g]), 32'(3'b101));
    wait_done();

    // Randomised frames, some back-to-back
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 6));
      issue(2'($urandom), CSW'($urandom), 1'($urandom), DW'($urandom), 2'($urandom));
      wait_done();
    end

    idle(BUSY_LEN + 10);
    for (int g = 0; g < 2; g++)
      chk($sformatf("u%0d sbq_drained", g), 32'(sbq[g].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
